// File: rtl/tmnt_video_pkg.sv
// Shared video constants and types for the TMNT palette path.
// Phase numbering, RGB555 field layout and the shadow helper.
package tmnt_video_pkg;

  localparam logic [1:0] PH_SRC = 2'd0;
  localparam logic [1:0] PH_LO  = 2'd1;
  localparam logic [1:0] PH_HI  = 2'd2;
  localparam logic [1:0] PH_CPU = 2'd3;

  localparam int CH_W  = 5;
  localparam int R_LSB = 0;
  localparam int G_LSB = 5;
  localparam int B_LSB = 10;

  typedef logic [10:0] pal_idx_t;

  function automatic logic [14:0] shade(
    input logic [14:0] c,
    input logic        s
  );
    return s ? {1'b0, c[14:11],
                1'b0, c[9:6],
                1'b0, c[4:1]} : c;
  endfunction

endpackage

// File: rtl/tmnt_palette_fetch_if.sv
// CPU palette-access port of the palette fetch block.
// The CPU side is the master; the fetch block serves it.
interface tmnt_palette_fetch_if #(
  parameter int PAL_AW = 12
);

  logic              CPU_REQ;
  logic              CPU_WR;
  logic [PAL_AW-1:0] CPU_A;
  logic [7:0]        CPU_D;
  logic [7:0]        CPU_Q;
  logic              CPU_ACK;

  modport master (
    output CPU_REQ, CPU_WR, CPU_A, CPU_D,
    input  CPU_Q, CPU_ACK
  );

  modport slave (
    input  CPU_REQ, CPU_WR, CPU_A, CPU_D,
    output CPU_Q, CPU_ACK
  );

endinterface

// File: rtl/tmnt_pal_prio.sv
// Registered sprite/tile source select feeding the palette fetch.
// Shadow register exists only with PALETTE_SHADOW_EN defined.
module tmnt_pal_prio
  import tmnt_video_pkg::*;
#(
  parameter logic SPR_BANK = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     cap_i,
  input  logic [9:0] ob_i,
  input  logic     nco0_i,
  input  logic     shad_i,
  input  logic     ncbk_i,
  input  logic [9:0] tile_col_i,
  input  logic     tile_pri_i,
  output pal_idx_t idx_o,
  output logic     shad_o,
  output logic     blank_n_o
);

  logic     spr_win;
  pal_idx_t idx_d;
  pal_idx_t idx_q;
  logic     blank_n_q;

  // A tile only beats the sprite when its pixel nibble is opaque
  assign spr_win = nco0_i &
    ~(tile_pri_i & (tile_col_i[3:0] != 4'd0));

  assign idx_d = spr_win ? {SPR_BANK, ob_i}
                         : {~SPR_BANK, tile_col_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      blank_n_q <= 1'b0;
    end else if (cap_i) begin
      idx_q     <= idx_d;
      blank_n_q <= ncbk_i;
    end
  end

`ifdef PALETTE_SHADOW_EN
  logic shad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shad_q <= 1'b0;
    end else if (cap_i) begin
      shad_q <= shad_i & spr_win;
    end
  end

  assign shad_o = shad_q;
`else
  logic unused_shad;

  assign unused_shad = shad_i;
  assign shad_o      = 1'b0;
`endif

  assign idx_o     = idx_q;
  assign blank_n_o = blank_n_q;

endmodule

// File: rtl/tmnt_palette_fetch.sv
// Palette fetch: two byte reads per pixel plus one CPU slot.
// PALETTE_SHADOW_EN enables shadow halving of sprite pixels.
module tmnt_palette_fetch
  import tmnt_video_pkg::*;
#(
  parameter int   PAL_AW   = 12,
  parameter logic SPR_BANK = 1'b1
) (
  input  logic              clk_24M,
  input  logic              nRES,
  input  logic              PIX_CE,
  input  logic [11:0]       OB,
  input  logic              NCO0,
  input  logic              SHAD,
  input  logic              NCBK,
  input  logic [9:0]        TILE_COL,
  input  logic              TILE_PRI,
  output logic [PAL_AW-1:0] PAL_A,
  input  logic [7:0]        PAL_DI,
  output logic [7:0]        PAL_DO,
  output logic              PAL_WE,
  tmnt_palette_fetch_if.slave cpu,
  output logic [4:0]        R,
  output logic [4:0]        G,
  output logic [4:0]        B,
  output logic              PIX_VALID
);

  logic [1:0]  ph_q;
  logic [1:0]  ph_d;
  logic [1:0]  ph;
  logic [7:0]  lo_q;
  logic [7:0]  hi_q;
  logic [7:0]  q_q;
  logic        srv_q;
  logic        wr_q;
  logic        ack_q;
  logic        vld_q;
  logic [14:0] rgb_q;
  logic [14:0] rgb_d;
  logic        serve;
  pal_idx_t    idx;
  logic        shad;
  logic        blank_n;
  logic        unused;

  assign unused = ^{OB[11:10], hi_q[7]};

  // An early PIX_CE restarts the pixel at phase 0
  assign ph    = PIX_CE ? PH_SRC : ph_q;
  assign ph_d  = ph + 2'd1;
  assign serve = (ph == PH_CPU) & cpu.CPU_REQ & ~srv_q;

  tmnt_pal_prio #(
    .SPR_BANK (SPR_BANK)
  ) u_prio (
    .clk        (clk_24M),
    .rst_n      (nRES),
    .cap_i      (ph == PH_SRC),
    .ob_i       (OB[9:0]),
    .nco0_i     (NCO0),
    .shad_i     (SHAD),
    .ncbk_i     (NCBK),
    .tile_col_i (TILE_COL),
    .tile_pri_i (TILE_PRI),
    .idx_o      (idx),
    .shad_o     (shad),
    .blank_n_o  (blank_n)
  );

  always_comb begin
    PAL_A  = PAL_AW'({idx, 1'b0});
    PAL_WE = 1'b0;
    PAL_DO = 8'h00;
    unique case (1'b1)
      ph == PH_HI: PAL_A = PAL_AW'({idx, 1'b1});
      ph == PH_CPU: begin
        if (serve) begin
          PAL_A  = cpu.CPU_A;
          PAL_WE = cpu.CPU_WR;
          PAL_DO = cpu.CPU_D;
        end else begin
          PAL_A  = PAL_AW'({idx, 1'b1});
        end
      end
      default: ;
    endcase
  end

  assign rgb_d = blank_n ? shade({hi_q[6:0], lo_q}, shad)
                         : 15'h0000;

  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      ph_q  <= PH_SRC;
      lo_q  <= 8'h00;
      hi_q  <= 8'h00;
      q_q   <= 8'h00;
      srv_q <= 1'b0;
      wr_q  <= 1'b0;
      ack_q <= 1'b0;
      vld_q <= 1'b0;
      rgb_q <= 15'h0000;
    end else begin
      ph_q  <= ph_d;
      srv_q <= serve;
      ack_q <= 1'b0;
      vld_q <= 1'b0;
      if (serve) wr_q <= cpu.CPU_WR;
      unique case (1'b1)
        ph == PH_SRC: begin
          vld_q <= 1'b1;
          rgb_q <= rgb_d;
          ack_q <= srv_q;
          if (srv_q && !wr_q) q_q <= PAL_DI;
        end
        ph == PH_HI:  lo_q <= PAL_DI;
        ph == PH_CPU: hi_q <= PAL_DI;
        default: ;
      endcase
    end
  end

  assign R           = rgb_q[R_LSB +: CH_W];
  assign G           = rgb_q[G_LSB +: CH_W];
  assign B           = rgb_q[B_LSB +: CH_W];
  assign PIX_VALID   = vld_q;
  assign cpu.CPU_Q   = q_q;
  assign cpu.CPU_ACK = ack_q;

endmodule

// File: tb/tb_tmnt_palette_fetch.sv
// Directed bench for tmnt_palette_fetch with a byte palette RAM model.
// Vector table for pixel colours, hand sequences for CPU and reset.
module tb_tmnt_palette_fetch;

  logic        clk = 1'b0;
  logic        nRES;
  logic        PIX_CE;
  logic [11:0] OB;
  logic        NCO0, SHAD, NCBK, TILE_PRI;
  logic [9:0]  TILE_COL;
  logic [11:0] PAL_A;
  logic [7:0]  PAL_DI = 8'h00;
  logic [7:0]  PAL_DO;
  logic        PAL_WE;
  logic [4:0]  R, G, B;
  logic        PIX_VALID;

  logic [7:0]  mem [4096];

  int pass_cnt = 0;
  int total    = 0;

  tmnt_palette_fetch_if #(.PAL_AW(12)) cpu_if ();

  tmnt_palette_fetch #(
    .PAL_AW   (12),
    .SPR_BANK (1'b1)
  ) dut (
    .clk_24M   (clk),
    .nRES      (nRES),
    .PIX_CE    (PIX_CE),
    .OB        (OB),
    .NCO0      (NCO0),
    .SHAD      (SHAD),
    .NCBK      (NCBK),
    .TILE_COL  (TILE_COL),
    .TILE_PRI  (TILE_PRI),
    .PAL_A     (PAL_A),
    .PAL_DI    (PAL_DI),
    .PAL_DO    (PAL_DO),
    .PAL_WE    (PAL_WE),
    .cpu       (cpu_if),
    .R         (R),
    .G         (G),
    .B         (B),
    .PIX_VALID (PIX_VALID)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (PAL_WE) mem[PAL_A] <= PAL_DO;
    PAL_DI <= mem[PAL_A];
  end

  typedef struct {
    logic [11:0] ob;
    logic        nco0;
    logic        shad;
    logic        ncbk;
    logic [9:0]  tcol;
    logic        tpri;
    logic [11:0] ea;
    logic [4:0]  er, eg, eb;
  } vec_t;

  typedef struct {
    logic        vld, vld_c, ack;
    logic [7:0]  q;
    logic [4:0]  r, g, b;
    logic [11:0] a1, a2, a3;
    logic        we1, we2, we3;
    logic [7:0]  do3;
  } snap_t;

  localparam int NV = 8;
  vec_t  tv [NV];
  vec_t  v;
  snap_t s;
  logic  ack_seen;

  function automatic vec_t mk(
    input logic [11:0] ob, input logic nco0, shad, ncbk,
    input logic [9:0] tc, input logic tp, input logic [11:0] ea,
    input logic [4:0] r, g, b);
    vec_t t;
    t.ob = ob; t.nco0 = nco0; t.shad = shad; t.ncbk = ncbk;
    t.tcol = tc; t.tpri = tp; t.ea = ea;
    t.er = r; t.eg = g; t.eb = b;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  task automatic apply(input vec_t a);
    OB = a.ob; NCO0 = a.nco0; SHAD = a.shad; NCBK = a.ncbk;
    TILE_COL = a.tcol; TILE_PRI = a.tpri;
  endtask

  task automatic step(input vec_t a, input logic req, wr,
                      input logic [11:0] ca, input logic [7:0] cd,
                      output snap_t o);
    @(negedge clk);
    PIX_CE = 1'b1;
    apply(a);
    cpu_if.CPU_REQ = req; cpu_if.CPU_WR = wr;
    cpu_if.CPU_A = ca; cpu_if.CPU_D = cd;
    @(negedge clk);
    PIX_CE = 1'b0;
    o.vld = PIX_VALID; o.r = R; o.g = G; o.b = B;
    o.ack = cpu_if.CPU_ACK; o.q = cpu_if.CPU_Q;
    o.a1 = PAL_A; o.we1 = PAL_WE;
    @(negedge clk);
    o.vld_c = PIX_VALID; o.a2 = PAL_A; o.we2 = PAL_WE;
    @(negedge clk);
    o.a3 = PAL_A; o.we3 = PAL_WE; o.do3 = PAL_DO;
  endtask

  task automatic chk_rgb(input string nm, input snap_t o, input vec_t e);
    chk(nm, 64'({o.vld, o.r, o.g, o.b}),
        64'({1'b1, e.er, e.eg, e.eb}));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h802] = 8'h1F; mem[12'h803] = 8'h7C;
    mem[12'h00A] = 8'h34; mem[12'h00B] = 8'h12;
    mem[12'h7FE] = 8'hFF; mem[12'h7FF] = 8'hFF;
    mem[12'hFFE] = 8'hE0; mem[12'hFFF] = 8'h03;

    tv[0] = mk(12'h001, 1, 0, 1, 10'h000, 0, 12'h802, 5'h1F, 5'h00, 5'h1F);
`ifdef PALETTE_SHADOW_EN
    tv[1] = mk(12'h001, 1, 1, 1, 10'h000, 0, 12'h802, 5'h0F, 5'h00, 5'h0F);
`else
    tv[1] = mk(12'h001, 1, 1, 1, 10'h000, 0, 12'h802, 5'h1F, 5'h00, 5'h1F);
`endif
    tv[2] = mk(12'h001, 1, 0, 1, 10'h005, 1, 12'h00A, 5'h14, 5'h11, 5'h04);
    tv[3] = mk(12'h001, 1, 0, 1, 10'h000, 1, 12'h802, 5'h1F, 5'h00, 5'h1F);
    tv[4] = mk(12'h001, 0, 1, 1, 10'h3FF, 0, 12'h7FE, 5'h1F, 5'h1F, 5'h1F);
    tv[5] = mk(12'hC01, 1, 0, 1, 10'h010, 1, 12'h802, 5'h1F, 5'h00, 5'h1F);
    tv[6] = mk(12'h3FF, 1, 0, 1, 10'h000, 0, 12'hFFE, 5'h00, 5'h1F, 5'h00);
    tv[7] = mk(12'h001, 1, 0, 0, 10'h000, 0, 12'h802, 5'h00, 5'h00, 5'h00);

    nRES = 1'b0; PIX_CE = 1'b0;
    apply(tv[0]);
    cpu_if.CPU_REQ = 1'b0; cpu_if.CPU_WR = 1'b0;
    cpu_if.CPU_A = 12'h000; cpu_if.CPU_D = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        64'({R, G, B, PIX_VALID, cpu_if.CPU_ACK, cpu_if.CPU_Q,
             PAL_A, PAL_WE, PAL_DO}), 64'd0);
    nRES = 1'b1;

    for (int i = 0; i <= NV; i++) begin
      v = tv[0];
      if (i < NV) v = tv[i];
      step(v, 1'b0, 1'b0, 12'h000, 8'h00, s);
      if (i > 0) begin
        chk_rgb($sformatf("rgb_v%0d", i - 1), s, tv[i - 1]);
        chk($sformatf("vld_pulse_v%0d", i - 1), 64'(s.vld_c), 64'd0);
      end
      if (i < NV) begin
        chk($sformatf("addr_lo_v%0d", i), 64'(s.a1), 64'(v.ea));
        chk($sformatf("addr_hi_v%0d", i), 64'(s.a2), 64'(v.ea | 12'h001));
        chk($sformatf("we_idle_v%0d", i), 64'({s.we1, s.we2, s.we3}), 64'd0);
      end
    end

    v = tv[0];
    step(v, 1'b1, 1'b1, 12'h123, 8'hA5, s);
    chk("cpu_wr_we_early", 64'({s.we1, s.we2}), 64'd0);
    chk("cpu_wr_ph3", 64'({s.we3, s.a3, s.do3}), 64'({1'b1, 12'h123, 8'hA5}));
    chk("cpu_wr_vid_addr", 64'(s.a1), 64'h802);
    step(v, 1'b1, 1'b0, 12'h123, 8'h00, s);
    chk("cpu_wr_ack", 64'(s.ack), 64'd1);
    chk("cpu_wr_q_hold", 64'(s.q), 64'd0);
    chk_rgb("cpu_wr_rgb", s, v);
    chk("cpu_rd_ph3", 64'({s.we3, s.a3}), 64'({1'b0, 12'h123}));
    step(v, 1'b0, 1'b0, 12'h000, 8'h00, s);
    chk("cpu_rd_ack_q", 64'({s.ack, s.q}), 64'({1'b1, 8'hA5}));
    chk_rgb("cpu_rd_rgb", s, v);
    step(v, 1'b0, 1'b0, 12'h000, 8'h00, s);
    chk("cpu_no_extra_ack", 64'(s.ack), 64'd0);
    chk_rgb("cpu_after_rgb", s, v);

    @(negedge clk);
    PIX_CE = 1'b1;
    apply(v);
    cpu_if.CPU_REQ = 1'b1; cpu_if.CPU_WR = 1'b0; cpu_if.CPU_A = 12'h123;
    @(negedge clk);
    PIX_CE = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_srv_addr", 64'(PAL_A), 64'h123);
    nRES = 1'b0;
    #1;
    chk("rst_mid_outs",
        64'({R, G, B, PIX_VALID, cpu_if.CPU_ACK, cpu_if.CPU_Q,
             PAL_A, PAL_WE, PAL_DO}), 64'd0);
    ack_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ack_seen = ack_seen | cpu_if.CPU_ACK;
    end
    chk("rst_no_ack", 64'(ack_seen), 64'd0);
    cpu_if.CPU_REQ = 1'b0;
    nRES = 1'b1;

    step(v, 1'b0, 1'b0, 12'h000, 8'h00, s);
    chk("rst_resume_addr", 64'(s.a1), 64'h802);
    step(v, 1'b0, 1'b0, 12'h000, 8'h00, s);
    chk_rgb("rst_resume_rgb", s, v);
    chk("rst_resume_noack", 64'(s.ack), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/tmnt_palette_fetch.md
Name: tmnt_palette_fetch

Overview:
- Downstream consumer of the sprite data processor's pixel stream: takes the sprite pixel (OB, opaque/shadow flags) and the tilemap pixel, picks a winner, and fetches the 16-bit colour from byte-wide palette RAM in two reads per pixel.
- Outputs registered 5:5:5 RGB with blanking and shadow applied.
- Time-multiplexes one CPU palette access slot per pixel.

Parameters:
- PAL_AW, 12, palette RAM byte address width (4 KB).
- SPR_BANK, 1, value of palette index bit 10 for sprite pixels; tile pixels use ~SPR_BANK.

Ports:
- clk_24M  in  1  sole clock.
- nRES  in  1  asynchronous active-low reset.
- PIX_CE  in  1  one-cycle strobe every 4 clk_24M cycles; marks pixel phase 0.
- OB  in  12  sprite colour: [11:4] palette, [3:0] pixel.
- NCO0  in  1  high when OB[3:0] != 0 (sprite opaque).
- SHAD  in  1  shadow request for the current pixel.
- NCBK  in  1  composite blank, active low.
- TILE_COL  in  10  tilemap colour index.
- TILE_PRI  in  1  high: an opaque tile beats the sprite.
- PAL_A  out  PAL_AW  palette RAM address.
- PAL_DI  in  8  palette RAM read data (1-cycle latency).
- PAL_DO  out  8  palette RAM write data.
- PAL_WE  out  1  palette RAM write enable.
- CPU_REQ  in  1  level request.
- CPU_WR  in  1  1 = write.
- CPU_A  in  PAL_AW  CPU byte address.
- CPU_D  in  8  CPU write data.
- CPU_Q  out  8  CPU read data.
- CPU_ACK  out  1  one-cycle done pulse.
- R, G, B  out  5 each  colour output.
- PIX_VALID  out  1  high for one cycle when RGB updates.

Behaviour:
- Phase counter ph[1:0]: PIX_CE forces ph to 1 on the next edge; otherwise ph increments mod 4. The PIX_CE cycle is phase 0. An early PIX_CE restarts the sequence. Any CPU write already driven completes; an interrupted CPU read is re-served later and is not acked.
- Phase 0 edge: capture the source.
  - spr_win = NCO0 & ~(TILE_PRI & (TILE_COL[3:0] != 0)).
  - idx[10:0] = spr_win ? {SPR_BANK, OB[9:0]} : {~SPR_BANK, TILE_COL}.
  - Register idx, SHAD & spr_win, and NCBK.
- Phase 1: PAL_A = {idx, 1'b0} (low byte).
- Phase 2: PAL_A = {idx, 1'b1}; latch PAL_DI into lo.
- Phase 3: latch PAL_DI into hi. If CPU_REQ and no ack is pending:
  - PAL_A = CPU_A.
  - PAL_WE = CPU_WR, PAL_DO = CPU_D.
  - Otherwise PAL_A holds the hi address and PAL_WE = 0.
- Next phase 0 edge:
  - word = {hi, lo}: R = word[4:0], G = word[9:5], B = word[14:10]; bit 15 is ignored.
  - If the registered shadow flag is set, each channel is right-shifted by 1.
  - If the registered NCBK = 0, R = G = B = 0.
  - PIX_VALID pulses.
  - If a CPU access was served at phase 3: CPU_ACK pulses and CPU_Q = PAL_DI (for a write, CPU_Q holds its previous value).
- Latency: sampled at PIX_CE edge N, RGB valid after edge N+4.
- CPU throughput: at most one access per pixel. CPU_REQ still high in the cycle after CPU_ACK is treated as a new request, served at the following phase 3. CPU access runs during active video and blanking alike; video never stalls.
- PAL_WE is asserted only in phase 3.
- Reset: all outputs 0, PAL_A = 0, ph = 0, pending CPU access discarded, no ack issued. Reset mid-access does not retry.

Optional Feature:
- PALETTE_SHADOW_EN
  - Defined: shadow halving as above.
  - Undefined: SHAD is ignored, colour passes unmodified, and the shadow register is not built.

Decomposition:
- Shared package tmnt_video_pkg:
  - Phase constants PH_SRC/PH_LO/PH_HI/PH_CPU = 0..3.
  - RGB555 field offsets.
  - Typedef pal_idx_t [10:0].
- Sub-module tmnt_pal_prio: registered source select (spr_win, idx, shadow, blank). It is isolated so it can later be swapped for a priority-PROM version.

Test Plan:
- RAM preloaded lo/hi at byte addr 0x802/0x803 = 0x1F/0x7C; OB=0x001, NCO0=1, TILE_PRI=0, SHAD=0, NCBK=1, SPR_BANK=1 -> R=0x1F, G=0x00, B=0x1F, four cycles after PIX_CE.
- Same pixel with SHAD=1 -> R=0x0F, G=0x00, B=0x0F; with the macro undefined -> R=0x1F, B=0x1F.
- TILE_COL=0x005, TILE_PRI=1, sprite opaque -> reads at 0x00A/0x00B; with TILE_COL=0x000 the sprite wins (0x802/0x803).
- NCBK=0 with any RAM data -> R=G=B=0 while PIX_VALID still pulses.
- CPU write 0xA5 to 0x123 during active video:
  - PAL_WE is asserted only in phase 3 with PAL_A=0x123.
  - CPU_ACK fires at the next phase 0.
  - A following read returns CPU_Q=0xA5.
  - Video RGB is undisturbed.
- nRES pulled low at phase 3 with CPU_REQ high -> no CPU_ACK, all outputs 0. After release and PIX_CE, normal fetch resumes within 4 cycles.
